single_port_ram_be: RTL and testbench

//  Parametrised single-port synchronous RAM, next generation of the team's 8x8 RAM.
//  - Separate wdata/rdata buses with a valid/ready request handshake.
//  - Per-byte write enables; full 2**ADDR_WIDTH depth.
//  - Optional output register; hardware clear engine zeroes every word after reset or on request.
//  - Used as local scratch/buffer memory behind a simple request master.

---
 rtl/single_port_ram_be.sv | 178 +++++++++++++++++
 tb/tb_single_port_ram_be.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_port_ram_be.sv
// ----------------------------------------------------------------------------
// single_port_ram_be
//   Parametrised single-port synchronous RAM with per-byte write enables, a
//   valid/ready request port, an optional output register and a hardware
//   clear engine that zeroes every word after reset or on request.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (combinational)
//   req_we     1 = write, 0 = read
//   addr       word address
//   wdata      write data
//   wbe        byte enables, bit i controls wdata[8i+7:8i]
//   clear      request to zero the whole array
//   rd_valid   one-cycle pulse per completed read
//   rdata      read data, held between reads
//   busy       clear engine running
//
// DATA_WIDTH must be a multiple of 8.
// ----------------------------------------------------------------------------
module single_port_ram_be #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    clear,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  // Pointer is one bit wider than the address so the last word is reached
  // without the pointer wrapping back to zero first.
  localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]          state_reg;
  logic [0:0]          state_next;
  logic [ADDR_WIDTH:0] clr_ptr_reg;
  logic [ADDR_WIDTH:0] clr_ptr_next;

  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_BYTES-1:0]  lane_we;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_valid_s1_reg;

  // --------------------------------------------------------------------------
  // Clear engine / request FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    case (state_reg)
      ST_CLEAR: begin
        clr_ptr_next = clr_ptr_reg + PTR_ONE;
        if (clr_ptr_reg == PTR_LAST) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        if (clear) begin
          state_next   = ST_CLEAR;
          clr_ptr_next = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  assign busy      = (state_reg == ST_CLEAR);
  // clear has priority over a request arriving in the same cycle.
  assign req_ready = (state_reg == ST_IDLE) && !clear;
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign wr_accept = accept && req_we;

  // While clearing, the single write port is owned by the clear engine.
  assign mem_waddr = busy ? clr_ptr_reg[ADDR_WIDTH-1:0] : addr;
  assign mem_wdata = busy ? '0 : wdata;

  // --------------------------------------------------------------------------
  // Storage: one byte-wide array per lane so each byte enable maps directly
  // onto its own write enable.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : gen_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rd_lane_reg;

      assign lane_we[gi] = busy || (wr_accept && wbe[gi]);

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          mem_lane[mem_waddr] <= mem_wdata[8*gi +: 8];
        end
      end

      // Registered read; only updated by an accepted read so the value is
      // held between reads.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_lane_reg <= '0;
        end else if (rd_accept) begin
          rd_lane_reg <= mem_lane[addr];
        end
      end

      assign rd_word[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_s1_reg <= 1'b0;
    end else begin
      rd_valid_s1_reg <= rd_accept;
    end
  end

  // --------------------------------------------------------------------------
  // Optional output register
  // --------------------------------------------------------------------------
  generate
    if (OUT_REG != 0) begin : gen_out_reg
      logic                  rd_valid_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_valid_reg <= 1'b0;
          rdata_reg    <= '0;
        end else begin
          rd_valid_reg <= rd_valid_s1_reg;
          if (rd_valid_s1_reg) begin
            rdata_reg <= rd_word;
          end
        end
      end

      assign rd_valid = rd_valid_reg;
      assign rdata    = rdata_reg;
    end else begin : gen_no_out_reg
      assign rd_valid = rd_valid_s1_reg;
      assign rdata    = rd_word;
    end
  endgenerate

endmodule

// File: tb/tb_single_port_ram_be.sv
// ----------------------------------------------------------------------------
// tb_single_port_ram_be
//   Drives identical stimulus into an OUT_REG=0 and an OUT_REG=1 instance and
//   compares both against a behavioural memory model with latency queues.
// ----------------------------------------------------------------------------
module tb_single_port_ram_be;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic          clear     = 1'b0;
  logic [AW-1:0] addr      = '0;
  logic [DW-1:0] wdata     = '0;
  logic [NB-1:0] wbe       = '0;

  logic          req_ready0, rd_valid0, busy0;
  logic [DW-1:0] rdata0;
  logic          req_ready1, rd_valid1, busy1;
  logic [DW-1:0] rdata1;

  always #5 clk = ~clk;

  single_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
    .req_we(req_we), .addr(addr), .wdata(wdata), .wbe(wbe), .clear(clear),
    .rd_valid(rd_valid0), .rdata(rdata0), .busy(busy0)
  );

  single_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .addr(addr), .wdata(wdata), .wbe(wbe), .clear(clear),
    .rd_valid(rd_valid1), .rdata(rdata1), .busy(busy1)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left;
  int            cyc = 0;
  rd_t           q0[$];
  rd_t           q1[$];
  logic [DW-1:0] last0, last1;
  bit            last_accept;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    clear_left = DEPTH;
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    last_accept = 1'b0;
  endtask

  // One clock cycle: check status before the edge, update the model at the
  // edge, check read outputs just after it.
  task automatic cycle();
    bit            ready;
    bit            acc;
    bit            ev0, ev1;
    logic [DW-1:0] rd_val;
    #1;
    ready = (clear_left == 0) && !clear;
    chk("busy0", busy0, clear_left > 0);
    chk("busy1", busy1, clear_left > 0);
    chk("req_ready0", req_ready0, ready);
    chk("req_ready1", req_ready1, ready);
    acc = req_valid && ready;
    @(posedge clk);
    cyc++;
    if (clear_left > 0) begin
      clear_left--;
    end else if (clear) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (acc) begin
      if (req_we) begin
        for (int b = 0; b < NB; b++)
          if (wbe[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rd_val = ref_mem[addr];
        q0.push_back('{due: cyc,     data: rd_val});
        q1.push_back('{due: cyc + 1, data: rd_val});
      end
    end
    last_accept = acc;
    #1;
    ev0 = (q0.size() > 0) && (q0[0].due == cyc);
    if (ev0) begin last0 = q0[0].data; void'(q0.pop_front()); end
    ev1 = (q1.size() > 0) && (q1[0].due == cyc);
    if (ev1) begin last1 = q1[0].data; void'(q1.pop_front()); end
    chk("rd_valid0", rd_valid0, ev0);
    chk("rd_valid1", rd_valid1, ev1);
    chk("rdata0", rdata0, last0);
    chk("rdata1", rdata1, last1);
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    clear     = 1'b0;
    cycle();
  endtask

  task automatic wait_idle();
    while (clear_left > 0) idle_cycle();
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NB-1:0] be);
    int tries = 0;
    req_valid = 1'b1;
    req_we    = we;
    addr      = a;
    wdata     = d;
    wbe       = be;
    clear     = 1'b0;
    cycle();
    while (!last_accept && tries < 40) begin
      cycle();
      tries++;
    end
    if (!last_accept) chk("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int n_low);
    reset     = 1'b0;
    req_valid = 1'b0;
    clear     = 1'b0;
    #1;
    model_reset();
    chk("rst_rd_valid0", rd_valid0, 1'b0);
    chk("rst_rd_valid1", rd_valid1, 1'b0);
    chk("rst_rdata0", rdata0, '0);
    chk("rst_rdata1", rdata1, '0);
    chk("rst_busy0", busy0, 1'b1);
    chk("rst_busy1", busy1, 1'b1);
    chk("rst_ready0", req_ready0, 1'b0);
    chk("rst_ready1", req_ready1, 1'b0);
    repeat (n_low) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int wait_cnt;

    // Reset and initial clear: 16 busy cycles, then every word reads 0.
    #2;
    do_reset(2);
    busy_cnt = 0;
    while (clear_left > 0 && busy_cnt < 40) begin
      if (busy0 === 1'b1) busy_cnt++;
      idle_cycle();
    end
    chk("init_busy_cycles", busy_cnt, 16);
    for (int k = 0; k < DEPTH; k++) issue(1'b0, AW'(k), '0, '0);
    repeat (3) idle_cycle();

    // Full write then read.
    issue(1'b1, 4'd3, 16'hA55A, 2'b11);
    issue(1'b0, 4'd3, '0, '0);
    repeat (2) idle_cycle();
    chk("rd_a55a_0", rdata0, 16'hA55A);
    chk("rd_a55a_1", rdata1, 16'hA55A);

    // Partial byte write and empty byte mask.
    issue(1'b1, 4'd3, 16'hFFFF, 2'b01);
    issue(1'b0, 4'd3, '0, '0);
    repeat (2) idle_cycle();
    chk("rd_a5ff_0", rdata0, 16'hA5FF);
    issue(1'b1, 4'd3, 16'h1234, 2'b00);
    issue(1'b0, 4'd3, '0, '0);
    repeat (2) idle_cycle();
    chk("rd_a5ff_1", rdata1, 16'hA5FF);

    // Fill and read back-to-back, including the last address.
    for (int k = 0; k < DEPTH; k++) issue(1'b1, AW'(k), DW'(k * 16'h0101), 2'b11);
    for (int k = 0; k < DEPTH; k++) issue(1'b0, AW'(k), '0, '0);
    repeat (2) idle_cycle();
    chk("rd_last_0", rdata0, 16'h0F0F);
    chk("rd_last_1", rdata1, 16'h0F0F);

    // clear and request together: clear wins, held request waits 16 busy cycles.
    req_valid = 1'b1; req_we = 1'b0; addr = 4'd7; clear = 1'b1;
    cycle();
    chk("clear_wins", last_accept, 1'b0);
    clear = 1'b0;
    wait_cnt = 0;
    while (!last_accept && wait_cnt < 40) begin
      cycle();
      wait_cnt++;
    end
    req_valid = 1'b0;
    chk("held_wait", wait_cnt, 17);
    repeat (2) idle_cycle();
    chk("post_clear_rd", rdata1, 16'h0000);

    // Read in flight when a clear starts returns pre-clear data.
    issue(1'b1, 4'd5, 16'h1234, 2'b11);
    issue(1'b0, 4'd5, '0, '0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("preclear_rd1", rdata1, 16'h1234);
    wait_idle();

    // Reset five cycles into a clear.
    clear = 1'b1;
    cycle();
    repeat (5) idle_cycle();
    do_reset(2);
    wait_idle();

    // Reset with a read in flight.
    issue(1'b1, 4'd9, 16'hBEEF, 2'b11);
    issue(1'b0, 4'd9, '0, '0);
    do_reset(1);
    wait_idle();
    repeat (2) idle_cycle();

    // Randomised traffic, including clears while busy.
    for (int n = 0; n < 600; n++) begin
      clear     = ($urandom_range(0, 24) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1);
      addr      = AW'($urandom_range(0, DEPTH - 1));
      wdata     = DW'($urandom);
      wbe       = NB'($urandom_range(0, (1 << NB) - 1));
      cycle();
    end
    repeat (4) idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
